// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: prefix byte values,
// prefix-tracking FSM states and the decoded key event record.
package ps2_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;  // extended-key prefix
  localparam logic [7:0] PREFIX_BRK = 8'hF0;  // key-release prefix

  localparam int unsigned EVENT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Fold the prefixes collected so far into a complete event for a code byte.
  function automatic ps2_event_t make_event(prefix_state_t st, logic [7:0] code);
    ps2_event_t ev;
    ev.ext  = (st == ST_EXT) || (st == ST_EXT_BRK);
    ev.brk  = (st == ST_BRK) || (st == ST_EXT_BRK);
    ev.code = code;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Decoded-event stream between the receiver (master) and its consumer (slave).
interface ps2_keyboard_rx_if;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       out_break;
  logic       out_ext;

  modport master (
    output out_valid,
    output out_code,
    output out_break,
    output out_ext,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_code,
    input  out_break,
    input  out_ext,
    output out_ready
  );

endinterface

// File: rtl/ps2_keyboard_rx_fifo.sv
// Event FIFO for the PS/2 receiver. The head entry is held in an output
// register so the consumer sees registered values; the register is reloaded
// from the storage array (registered read) every cycle, with a bypass when
// the entry being written is also the next head.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [9:0]                 push_data,
  output logic                       full,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [9:0]                 pop_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic          valid_reg;
  logic [9:0]    head_reg;
  logic          do_push;
  logic          do_pop;

  assign full      = (level_reg == LW'(DEPTH));
  assign do_pop    = valid_reg & pop_ready;
  assign do_push   = push & (~full | do_pop);
  assign pop_valid = valid_reg;
  assign pop_data  = head_reg;
  assign level     = level_reg;

  // Next read pointer and occupancy after this cycle's push/pop.
  always_comb begin
    rd_ptr_next = rd_ptr_reg + AW'(do_pop);
    level_next  = level_reg + LW'(do_push) - LW'(do_pop);
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers (wrap naturally modulo DEPTH) and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  // Registered head: bypass the write when it lands in the next head slot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_reg <= 1'b0;
      head_reg  <= '0;
    end else begin
      valid_reg <= (level_next != '0);
      if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
        head_reg <= push_data;
      end else begin
        head_reg <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 clock, deserialises 11-bit
// frames on its falling edge, folds E0/F0 prefixes into decoded key events
// and queues them in a FIFO.
// Optional feature macro: PS2_RX_TIMEOUT_EN -- abort a partial frame after
// TIMEOUT_CYCLES clk cycles without a PS/2 clock edge.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           ps2_clk,
  input  logic                           ps2_data,
  ps2_keyboard_rx_if.master              evt,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow,
  output logic                           frame_err
);

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   strobe;
  logic                   data_bit;

  logic [3:0]             bit_cnt_reg;
  logic [9:0]             shift_reg;
  prefix_state_t          state_reg;
  logic                   push_reg;
  ps2_event_t             push_evt_reg;
  logic                   frame_err_reg;
  logic                   overflow_reg;

  logic [7:0]             frame_byte;
  logic                   frame_ok;

  logic                   fifo_full;
  logic [9:0]             fifo_data;
  ps2_event_t             head_evt;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]          timeout_cnt_reg;
`endif

  // Both lines pass through equal-length synchronisers so the data sample
  // stays aligned with the detected clock edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign strobe   = clk_sync_reg[SYNC_STAGES-1] & ~clk_sync_reg[SYNC_STAGES-2];
  assign data_bit = data_sync_reg[SYNC_STAGES-2];

  // After ten strobes shift_reg holds {parity, data[7:0], start}; the stop
  // bit is the sample taken on the eleventh strobe.
  assign frame_byte = shift_reg[8:1];
  assign frame_ok   = ~shift_reg[0] & (^shift_reg[9:1]) & data_bit;

  // Frame deserialiser and prefix FSM, with registered push and error pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      state_reg     <= ST_IDLE;
      push_reg      <= 1'b0;
      push_evt_reg  <= '0;
      frame_err_reg <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      timeout_cnt_reg <= '0;
`endif
    end else begin
      push_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      if (strobe) begin
        if (bit_cnt_reg == 4'd10) begin
          bit_cnt_reg <= '0;
          if (frame_ok) begin
            case (state_reg)
              ST_IDLE: begin
                if (frame_byte == PREFIX_EXT) begin
                  state_reg <= ST_EXT;
                end else if (frame_byte == PREFIX_BRK) begin
                  state_reg <= ST_BRK;
                end else begin
                  push_reg     <= 1'b1;
                  push_evt_reg <= make_event(state_reg, frame_byte);
                end
              end
              ST_EXT: begin
                if (frame_byte == PREFIX_BRK) begin
                  state_reg <= ST_EXT_BRK;
                end else begin
                  push_reg     <= 1'b1;
                  push_evt_reg <= make_event(state_reg, frame_byte);
                  state_reg    <= ST_IDLE;
                end
              end
              default: begin
                push_reg     <= 1'b1;
                push_evt_reg <= make_event(state_reg, frame_byte);
                state_reg    <= ST_IDLE;
              end
            endcase
          end else begin
            state_reg     <= ST_IDLE;
            frame_err_reg <= 1'b1;
          end
        end else begin
          shift_reg   <= {data_bit, shift_reg[9:1]};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end
`ifdef PS2_RX_TIMEOUT_EN
      if (strobe || (bit_cnt_reg == 4'd0)) begin
        timeout_cnt_reg <= '0;
      end else if (timeout_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_cnt_reg <= '0;
        bit_cnt_reg     <= '0;
        state_reg       <= ST_IDLE;
        frame_err_reg   <= 1'b1;
      end else begin
        timeout_cnt_reg <= timeout_cnt_reg + TW'(1);
      end
`endif
    end
  end

  // Sticky overflow: a push was refused because the FIFO stayed full.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow_reg <= 1'b0;
    end else if (push_reg && fifo_full && !(evt.out_valid && evt.out_ready)) begin
      overflow_reg <= 1'b1;
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_reg),
    .push_data (push_evt_reg),
    .full      (fifo_full),
    .pop_valid (evt.out_valid),
    .pop_ready (evt.out_ready),
    .pop_data  (fifo_data),
    .level     (fifo_level)
  );

  assign head_evt      = fifo_data;
  assign evt.out_code  = head_evt.code;
  assign evt.out_break = head_evt.brk;
  assign evt.out_ext   = head_evt.ext;
  assign overflow      = overflow_reg;
  assign frame_err     = frame_err_reg;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed testbench for ps2_keyboard_rx: drives PS/2 frames bit by bit and
// checks decoded events, FIFO level/overflow and frame error pulses.
module tb_ps2_keyboard_rx;

  logic       clk;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] fifo_level;
  logic       overflow;
  logic       frame_err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [9:0] ev_q[$];
  int         err_cnt  = 0;
  int         peak_lvl = 0;

  ps2_keyboard_rx_if evt ();

  ps2_keyboard_rx #(
    .FIFO_DEPTH     (8),
    .SYNC_STAGES    (3),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .evt        (evt),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe the stream on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (evt.out_valid && evt.out_ready) begin
        ev_q.push_back({evt.out_ext, evt.out_break, evt.out_code});
        $display("event: code=%02h break=%0b ext=%0b", evt.out_code, evt.out_break, evt.out_ext);
      end
      if (frame_err) err_cnt = err_cnt + 1;
      if (int'(fifo_level) > peak_lvl) peak_lvl = int'(fifo_level);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  // One 11-bit frame; bad_par flips the odd-parity bit.
  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    repeat (30) @(posedge clk);
    $display("frame sent: %02h bad_parity=%0b", b, bad_par);
  endtask

  task automatic expect_one(input string tag, input int base, input logic [7:0] code,
                            input logic brk, input logic ext);
    logic [9:0] ev;
    check_eq({tag, "_count"}, 32'(ev_q.size() - base), 32'd1);
    if (ev_q.size() > base) begin
      ev = ev_q[base];
      check_eq({tag, "_code"}, 32'(ev[7:0]), 32'(code));
      check_eq({tag, "_break"}, 32'(ev[8]), 32'(brk));
      check_eq({tag, "_ext"}, 32'(ev[9]), 32'(ext));
    end
  endtask

  initial begin
    int base;
    int errs;
    logic [7:0] want;
    logic [9:0] ev;

    ps2_clk       = 1'b1;
    ps2_data      = 1'b1;
    evt.out_ready = 1'b1;
    do_reset();
    @(negedge clk);

    // Reset state
    check_eq("rst_valid", 32'(evt.out_valid), 32'd0);
    check_eq("rst_code", 32'(evt.out_code), 32'h00);
    check_eq("rst_break", 32'(evt.out_break), 32'd0);
    check_eq("rst_ext", 32'(evt.out_ext), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);

    // Plain make code 1C
    base = ev_q.size();
    send_frame(8'h1C, 1'b0);
    expect_one("make1c", base, 8'h1C, 1'b0, 1'b0);
    check_eq("make1c_err", 32'(err_cnt), 32'd0);

    // Break 1C
    base = ev_q.size();
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    expect_one("brk1c", base, 8'h1C, 1'b1, 1'b0);
    check_eq("brk1c_peak_level", 32'(peak_lvl), 32'd1);

    // Extended break 75
    base = ev_q.size();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    expect_one("extbrk75", base, 8'h75, 1'b1, 1'b1);

    // Bad parity then a good frame
    base = ev_q.size();
    errs = err_cnt;
    send_frame(8'h1C, 1'b1);
    check_eq("badpar_err_pulse", 32'(err_cnt - errs), 32'd1);
    check_eq("badpar_no_push", 32'(ev_q.size() - base), 32'd0);
    send_frame(8'h29, 1'b0);
    expect_one("after_err29", base, 8'h29, 1'b0, 1'b0);

    // Fill past capacity with the consumer stalled
    @(posedge clk); #1 evt.out_ready = 1'b0;
    base = ev_q.size();
    for (int c = 1; c <= 9; c++) send_frame(8'(c), 1'b0);
    @(negedge clk);
    check_eq("full_level", 32'(fifo_level), 32'd8);
    check_eq("full_overflow", 32'(overflow), 32'd1);
    check_eq("full_valid", 32'(evt.out_valid), 32'd1);
    check_eq("full_head", 32'(evt.out_code), 32'h01);
    @(posedge clk); #1 evt.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("drain_count", 32'(ev_q.size() - base), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (ev_q.size() > base + k) begin
        ev = ev_q[base + k];
        want = 8'(k + 1);
        check_eq($sformatf("drain_code%0d", k), 32'(ev[7:0]), 32'(want));
      end
    end
    check_eq("drain_level", 32'(fifo_level), 32'd0);
    check_eq("drain_overflow_sticky", 32'(overflow), 32'd1);

    // Partial frame followed by a long idle gap
    base = ev_q.size();
    errs = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (1500) @(posedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    check_eq("timeout_err_pulse", 32'(err_cnt - errs), 32'd1);
    check_eq("timeout_bitcnt", 32'(dut.bit_cnt_reg), 32'd0);
`else
    check_eq("hold_no_err", 32'(err_cnt - errs), 32'd0);
    check_eq("hold_bitcnt", 32'(dut.bit_cnt_reg), 32'd5);
    do_reset();
    check_eq("reset_overflow_clear", 32'(overflow), 32'd0);
`endif
    send_frame(8'h29, 1'b0);
    expect_one("post_gap29", base, 8'h29, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, decoded-event FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter SYNC_STAGES, default 3, ps2_clk synchroniser length; SHALL be >= 3.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, clk cycles of ps2_clk inactivity that abort a partial frame; used only with PS2_RX_TIMEOUT_EN.
REQ-004 clk  input  1  system clock; reset resetn, synchronous, active-low; clock clk.
REQ-005 resetn  input  1  synchronous active-low reset.
REQ-006 ps2_clk  input  1  asynchronous PS/2 clock line.
REQ-007 ps2_data  input  1  PS/2 data line.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  consumer accepts head entry.
REQ-010 out_code  output  8  head scan code.
REQ-011 out_break  output  1  head is a key release (F0 prefix seen).
REQ-012 out_ext  output  1  head is extended (E0 prefix seen).
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-014 overflow  output  1  sticky; an event was dropped.
REQ-015 frame_err  output  1  one-cycle pulse on rejected or aborted frame.

Function
REQ-016 Sample strobe SHALL be the synchronised falling edge of ps2_clk (sync[MSB]=1, sync[MSB-1]=0); ps2_data sampled on that strobe.
REQ-017 Frame = 11 strobes: start 0, 8 data bits LSB first, odd parity over data+parity, stop 1; bit counter 0..10, returning to 0 after the 11th strobe.
REQ-018 On the 11th strobe, valid frame SHALL advance the prefix FSM; any start/parity/stop failure SHALL discard the byte, pulse frame_err next cycle, force FSM to IDLE.
REQ-019 Prefix FSM states IDLE, EXT, BRK, EXT_BRK: byte E0 in IDLE -> EXT; F0 in IDLE -> BRK; F0 in EXT -> EXT_BRK; any other byte in any state -> push {ext,brk,code}, return to IDLE; E0 outside IDLE treated as a code byte.
REQ-020 Push SHALL occur on the clk edge following the stop-bit strobe; out_valid/out_code reflect it one cycle later when FIFO was empty.
REQ-021 Pop on out_valid & out_ready; out_* SHALL be registered FIFO head, stable while out_valid & !out_ready.
REQ-022 Push while full and no pop same cycle: entry dropped, FIFO unchanged, overflow set until reset; push and pop same cycle when full: both succeed, level unchanged.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL equal FIFO_DEPTH when full, 0 when empty.

Reset
REQ-024 resetn=0 SHALL set synchroniser to all 1s, bit counter 0, FSM IDLE, FIFO empty, out_valid 0, out_code 00, out_break 0, out_ext 0, fifo_level 0, overflow 0, frame_err 0; a partial frame in progress is discarded.

Configuration
REQ-025 Macro PS2_RX_TIMEOUT_EN defined: counter of clk cycles since last strobe while bit counter != 0; reaching TIMEOUT_CYCLES SHALL clear bit counter, FSM to IDLE, pulse frame_err.
REQ-026 Macro undefined: no timeout logic; partial frame held indefinitely until completed or reset.

Structure
REQ-027 Package ps2_pkg SHALL hold prefix constants (E0, F0), FSM state enum, and the event struct {ext, brk, code[7:0]}.
REQ-028 FIFO SHALL be sub-module ps2_event_fifo (parameter DEPTH, width 10, valid/ready pop, push/full).

Verification
REQ-029 Frame 0x1C, parity 0, stop 1, out_ready=1 -> one event code 1C, break 0, ext 0; frame_err stays 0.
REQ-030 Frames F0,1C -> single event code 1C, break 1, ext 0; fifo_level peaks at 1.
REQ-031 Frames E0,F0,75 -> single event code 75, break 1, ext 1.
REQ-032 Frame 0x1C with parity 1 -> frame_err pulse, no push, next frame 0x29 -> code 29 break 0.
REQ-033 FIFO_DEPTH 8, out_ready=0, send codes 01..09 -> fifo_level 8, overflow 1, head 01; then drain -> 01..08 in order.
REQ-034 With PS2_RX_TIMEOUT_EN, TIMEOUT_CYCLES 1000: 5 bits then 1500 idle cycles -> frame_err pulse, counter 0; subsequent frame 0x29 -> code 29.
